// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM state encoding and bus mode constants.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      HOLD,
      GAP,
      WAIT
   } spi_state_t;

   localparam logic CPOL      = 1'b0;
   localparam logic CPHA      = 1'b0;
   localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: one-cycle tick after every CLK_DIV enabled cycles.
// Latency: first tick CLK_DIV cycles after clr; no backpressure, holds count while en is low.
module spi_clk_div #(
   parameter int CLK_DIV = 4,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   logic [CNT_W-1:0] cnt;

   assign tick = en && (cnt == CNT_W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: serialises accepted words MSB first, captures miso into rx_data.
// Latency: done 2*BITS*CLK_DIV cycles after accept; backpressure via ready, start ignored when low.
module spi_master
   import spi_pkg::*;
#(
   parameter int BITS    = 8,
   parameter int CLK_DIV = 4,
   parameter int CNT_W   = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [BITS-1:0] tx_data,
   input  logic            last,
   output logic            ready,
   output logic            busy,
   output logic            done,
   output logic [BITS-1:0] rx_data,
   output logic            sck,
   output logic            mosi,
   input  logic            miso,
   output logic            ssel
);

   localparam int BC_W = $clog2(BITS + 1);

   spi_state_t      state, state_nxt;
   logic            accept, tick, div_en, last_q;
   logic            sck_fall, word_end;
   logic [BITS-2:0] tx_rem;
   logic [BITS-1:0] rx_shift;
   logic [BC_W-1:0] bit_cnt;

   assign accept   = start && ready;
   assign div_en   = (state == SHIFT) || (state == HOLD) || (state == GAP);
   assign sck_fall = (state == SHIFT) && tick && sck;
   assign word_end = sck_fall && (bit_cnt == BC_W'(BITS));
   assign busy     = ~ssel;

   spi_clk_div #(
      .CLK_DIV (CLK_DIV),
      .CNT_W   (CNT_W)
   ) u_clk_div (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (accept),
      .en    (div_en),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      case (state)
         IDLE, WAIT: begin
            ready = 1'b1;
            if (start) state_nxt = SHIFT;
         end
         SHIFT:   if (word_end) state_nxt = last_q ? HOLD : WAIT;
         HOLD:    if (tick) state_nxt = GAP;
         GAP:     if (tick) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // tx_rem holds the bits still to be sent after the one currently on mosi.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck      <= CPOL;
         mosi     <= 1'b0;
         ssel     <= 1'b1;
         done     <= 1'b0;
         rx_data  <= '0;
         rx_shift <= '0;
         tx_rem   <= '0;
         bit_cnt  <= '0;
         last_q   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            ssel    <= 1'b0;
            mosi    <= tx_data[BITS-1];
            tx_rem  <= tx_data[BITS-2:0];
            last_q  <= last;
            bit_cnt <= '0;
         end else if (state == SHIFT && tick) begin
            sck <= ~sck;
            if (!sck) begin
               rx_shift <= {rx_shift[BITS-2:0], miso};
               bit_cnt  <= bit_cnt + BC_W'(1);
            end else if (bit_cnt < BC_W'(BITS)) begin
               mosi   <= tx_rem[BITS-2];
               tx_rem <= tx_rem << 1;
            end else begin
               rx_data <= rx_shift;
               done    <= 1'b1;
            end
         end else if (state == HOLD && tick) begin
            ssel <= 1'b1;
            mosi <= 1'b0;
         end
      end
   end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 master (CPOL=0, CPHA=0, MSB first, active-low select) that drives the SPI_slave end of the same link. Accepts parallel words over a ready/start handshake, serialises them on `mosi` and captures `miso` into `rx_data`. Consecutive words can share one select assertion, giving multi-byte transactions. It sits between a host-side controller and the external SPI pins.

## Interface
- `BITS`, 8: word width; must be ≥ 2.
- `CLK_DIV`, 4: `clk` cycles per SCK half-period. Must be ≥ 3 so a 2-flop-synchronising slave sees every edge.
- `CNT_W`, 8: width of the half-period counter; must satisfy 2^CNT_W > CLK_DIV.
- `clk`  in  1  system clock, all logic on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; accepted only on a cycle with `ready`=1.
- `tx_data`  in  BITS  word to send; sampled on acceptance.
- `last`  in  1  sampled on acceptance; 1 = release `ssel` after this word.
- `ready`  out  1  master can accept a word.
- `busy`  out  1  equals ~`ssel`.
- `done`  out  1  one-cycle pulse at the end of each word.
- `rx_data`  out  BITS  received word; valid from `done`, held until the next `done`.
- `sck`  out  1  serial clock, idle low.
- `mosi`  out  1  serial data out.
- `miso`  in  1  serial data in; sampled directly, no synchroniser.
- `ssel`  out  1  slave select, active-low.

## Operation
- States:
  - IDLE: `ssel`=1, `ready`=1.
  - SHIFT: word in flight.
  - HOLD: `ssel` still low after the last word.
  - GAP: `ssel` high, minimum deselect time.
  - WAIT: `ssel` low, between words, `ready`=1.
- IDLE/WAIT + `start` → SHIFT:
  - `ssel`←0, `mosi`←`tx_data[BITS-1]`.
  - tx shift register←`tx_data`; `last` latched.
  - bit counter cleared; half-period counter cleared.
- SHIFT: every CLK_DIV cycles `sck` toggles.
  - 0→1 edge: `rx_shift`←{`rx_shift[BITS-2:0]`,`miso`}, bit counter +1.
  - 1→0 edge:
    - If the bit counter is below BITS: tx shifts left and `mosi`←next bit.
    - Else (BITS-th falling edge): `rx_data`←`rx_shift`, `done`=1, then go to HOLD if `last`=1, or to WAIT if `last`=0.
- WAIT: `sck`=0, `mosi` holds the final bit. The next accepted `start` continues the same transaction.
- HOLD: CLK_DIV cycles, then `ssel`←1, `mosi`←0 → GAP.
- GAP: CLK_DIV cycles → IDLE.
- `start` while `ready`=0 is ignored; it is neither queued nor an error.
- `tx_data` and `last` may change freely once a word is accepted.

## Timing
- Reset values: `sck`=0, `mosi`=0, `ssel`=1, `ready`=1, `busy`=0, `done`=0, `rx_data`=0; state IDLE.
- Let T be the accept edge.
  - Rising SCK edge k (k=0..BITS-1) occurs at T+(2k+1)·CLK_DIV.
  - Falling edges occur at T+2k·CLK_DIV for k≥1.
  - `done` and `ready` (when `last`=0) are asserted at T+2·BITS·CLK_DIV. With the defaults this is T+64.
- `last`=1:
  - `ssel` rises at T+(2·BITS+1)·CLK_DIV.
  - `ready` rises at T+(2·BITS+2)·CLK_DIV.
- `ready` falls on the cycle after acceptance.
- Back-to-back words (`start` held high in WAIT): accepted the cycle `ready` rises. The next first rising edge follows CLK_DIV cycles later, so SCK low time is never below CLK_DIV.
- `rst_n` low mid-transfer: all outputs take reset values immediately and asynchronously. The partial word is discarded, `done` does not pulse, and `rx_data` is cleared.

## Structure
- `spi_pkg`: state enum (IDLE, SHIFT, HOLD, GAP, WAIT) and the mode constants CPOL=0, CPHA=0, MSB_FIRST=1, shared with future SPI blocks.
- One sub-module: `spi_clk_div`, the half-period counter. It takes clear and enable and emits a one-cycle `tick` every CLK_DIV cycles. The FSM, shift registers and bit counter stay in `spi_master`.

## Test plan
- Single word, `tx_data`=8'hA5, `last`=1, slave returns 8'h3C → MOSI bits 1,0,1,0,0,1,0,1 sampled on the 8 rising edges. `done` at T+64, `rx_data`=8'h3C, `ssel` high at T+68, `ready` at T+72.
- Two words, 8'h01 with `last`=0 then 8'h80 with `last`=1 → `ssel` stays low across both words (16 SCK pulses). Slave reports two bytes received, values 8'h01 and 8'h80.
- `start` pulsed every cycle while busy → only one word is sent, exactly 8 SCK rising edges, no extra `done`.
- `rst_n` asserted at T+30 mid-word → at that same instant `ssel`=1, `sck`=0, `rx_data`=0, `ready`=1. No `done` follows.
- Parameter sweep BITS=16, CLK_DIV=3 with `tx_data`=16'hF00F, loopback `miso`=`mosi` → `rx_data`=16'hF00F, `done` at T+96. SCK high and low phases are each exactly 3 cycles.
